// File: rtl/capture_dump_deframer.sv
// Receiver for the UART capture dump: hunts the 15x0x55 + 0xAA sync pattern and reassembles
// 16-byte samples into 128-bit words. Define DEFRAMER_TIMEOUT_EN to enable the idle timeout.
module capture_dump_deframer #(
  parameter int unsigned SYNC_MIN = 15,
  parameter int unsigned TIMEOUT  = 20000
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic [7:0]     rx_data,
  input  logic           rx_valid,
  output logic [127:0]   word_data,
  output logic [8:0]     word_addr,
  output logic           word_valid,
  output logic           locked,
  output logic           frame_done,
  output logic           sync_error
);

  typedef enum logic [1:0] {StHunt, StData, StResync} state_e;

  localparam logic [3:0] SyncMin = 4'(SYNC_MIN);

  if (SYNC_MIN < 1 || SYNC_MIN > 15 || TIMEOUT < 1 || TIMEOUT > 65535) begin : g_param_check
    $error("capture_dump_deframer: SYNC_MIN or TIMEOUT out of range");
  end

  state_e         state_q, state_d;
  logic [3:0]     run_q, run_d;
  // Counts data bytes in DATA and sync bytes in RESYNC.
  logic [3:0]     byte_cnt_q, byte_cnt_d;
  logic [8:0]     addr_q, addr_d;
  logic [119:0]   asm_q, asm_d;
  logic [127:0]   word_data_q, word_data_d;
  logic [8:0]     word_addr_q, word_addr_d;
  logic           word_valid_q, word_valid_d;
  logic           frame_done_q, frame_done_d;
  logic           sync_error_q, sync_error_d;

`ifdef DEFRAMER_TIMEOUT_EN
  localparam logic [15:0] TimeoutVal = 16'(TIMEOUT);
  logic [15:0]    idle_q, idle_d;
`endif

  always_comb begin
    state_d      = state_q;
    run_d        = run_q;
    byte_cnt_d   = byte_cnt_q;
    addr_d       = addr_q;
    asm_d        = asm_q;
    word_data_d  = word_data_q;
    word_addr_d  = word_addr_q;
    word_valid_d = 1'b0;
    frame_done_d = 1'b0;
    sync_error_d = 1'b0;
`ifdef DEFRAMER_TIMEOUT_EN
    idle_d       = idle_q;
`endif

    unique case (state_q)
      StHunt: begin
        if (rx_valid) begin
          if (rx_data == 8'h55) begin
            if (run_q != 4'hF) run_d = run_q + 4'd1;
          end else if (rx_data == 8'hAA && run_q >= SyncMin) begin
            state_d    = StData;
            addr_d     = '0;
            byte_cnt_d = '0;
            run_d      = '0;
          end else begin
            run_d = '0;
          end
        end
      end
      StData: begin
        if (rx_valid) begin
          asm_d      = {asm_q[111:0], rx_data};
          byte_cnt_d = byte_cnt_q + 4'd1;
          if (byte_cnt_q == 4'hF) begin
            word_data_d  = {asm_q, rx_data};
            word_addr_d  = addr_q;
            word_valid_d = 1'b1;
            addr_d       = addr_q + 9'd1;
            if (addr_q == 9'h1FF) begin
              frame_done_d = 1'b1;
              state_d      = StHunt;
              run_d        = '0;
            end else if (addr_q[3:0] == 4'hF) begin
              state_d = StResync;
            end
          end
        end
      end
      StResync: begin
        if (rx_valid) begin
          if (byte_cnt_q != 4'hF && rx_data == 8'h55) begin
            byte_cnt_d = byte_cnt_q + 4'd1;
          end else if (byte_cnt_q == 4'hF && rx_data == 8'hAA) begin
            state_d    = StData;
            byte_cnt_d = '0;
          end else begin
            // The offending byte is dropped, not fed back into the hunt.
            sync_error_d = 1'b1;
            state_d      = StHunt;
            run_d        = '0;
            byte_cnt_d   = '0;
          end
        end
      end
      default: state_d = StHunt;
    endcase

`ifdef DEFRAMER_TIMEOUT_EN
    // A byte in the same cycle always wins over an expiring timer.
    if (state_q == StHunt || rx_valid) begin
      idle_d = '0;
    end else if (idle_q + 16'd1 == TimeoutVal) begin
      idle_d       = '0;
      sync_error_d = 1'b1;
      state_d      = StHunt;
      run_d        = '0;
      byte_cnt_d   = '0;
    end else begin
      idle_d = idle_q + 16'd1;
    end
`endif
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StHunt;
      run_q        <= '0;
      byte_cnt_q   <= '0;
      addr_q       <= '0;
      asm_q        <= '0;
      word_data_q  <= '0;
      word_addr_q  <= '0;
      word_valid_q <= 1'b0;
      frame_done_q <= 1'b0;
      sync_error_q <= 1'b0;
`ifdef DEFRAMER_TIMEOUT_EN
      idle_q       <= '0;
`endif
    end else begin
      state_q      <= state_d;
      run_q        <= run_d;
      byte_cnt_q   <= byte_cnt_d;
      addr_q       <= addr_d;
      asm_q        <= asm_d;
      word_data_q  <= word_data_d;
      word_addr_q  <= word_addr_d;
      word_valid_q <= word_valid_d;
      frame_done_q <= frame_done_d;
      sync_error_q <= sync_error_d;
`ifdef DEFRAMER_TIMEOUT_EN
      idle_q       <= idle_d;
`endif
    end
  end

  assign word_data  = word_data_q;
  assign word_addr  = word_addr_q;
  assign word_valid = word_valid_q;
  assign frame_done = frame_done_q;
  assign sync_error = sync_error_q;
  assign locked     = (state_q != StHunt);

endmodule

// File: doc/capture_dump_deframer.md
# capture_dump_deframer

Host-side receiver for the logic analyzer's UART capture dump. It consumes the byte stream from a `UART` instance's `rxout`/`rxrdy`, hunts for the 15×0x55 + 0xAA sync pattern, and reassembles 16-byte samples into 128-bit words tagged with a 9-bit buffer address. It is the counterpart of the capture-dump transmitter and is used for hardware loopback testing and for a second board acting as a capture sink.

## Interface
- `SYNC_MIN`, 15: minimum run of 0x55 bytes before 0xAA that acquires lock in HUNT (1..15).
- `TIMEOUT`, 20000: inter-byte idle limit in `clk` cycles while locked (1..65535). Used only with the timeout feature.
- `clk`  in  1  system clock.
- `reset_n`  in  1  asynchronous active-low reset.
- `rx_data`  in  8  received byte; valid only when `rx_valid` is high.
- `rx_valid`  in  1  single-cycle strobe, one per received byte.
- `word_data`  out  128  assembled sample; first byte received is bits [127:120], 16th byte is [7:0].
- `word_addr`  out  9  buffer address of `word_data`, 0..511.
- `word_valid`  out  1  one-cycle strobe; `word_data`/`word_addr` are valid and held until the next strobe.
- `locked`  out  1  high while in DATA or RESYNC.
- `frame_done`  out  1  one-cycle strobe coincident with `word_valid` for address 511.
- `sync_error`  out  1  one-cycle strobe on protocol violation or timeout.

## Operation
- Stream format: 32 blocks. Each block is the sync pattern (15×0x55, then 0xAA) followed by 16 words of 16 bytes each, MSB byte first. Block b word w has address {b[4:0], w[3:0]}. No sync follows word 511.
- HUNT: 4-bit `run` counts consecutive 0x55 and saturates at 15.
  - 0xAA with `run >= SYNC_MIN` → DATA; address counter cleared to 0; byte counter cleared; `locked` set.
  - 0xAA with `run < SYNC_MIN`, or any byte other than 0x55 → `run` cleared.
- DATA: each byte is shifted into the assembly register; the 4-bit byte counter increments.
  - On the 16th byte, `word_data`, `word_addr` and `word_valid` update, and the address increments.
  - Address 511 → `frame_done`, then HUNT.
  - Address low nibble 0xF (and not 511) → RESYNC.
  - Otherwise stay in DATA.
- RESYNC: strict check. The next 15 bytes must be 0x55 and the 16th must be 0xAA, which returns to DATA with the address continuing. Any mismatching byte → `sync_error`, HUNT, `run` cleared; that byte is not reinterpreted.
- Relock after an error always restarts at address 0. Partial frames never raise `frame_done`.
- Data bytes equal to 0x55/0xAA have no special meaning in DATA.

## Timing
- All outputs reset to 0; state resets to HUNT with all counters 0.
- Latency: `word_valid` is asserted in the cycle after the `rx_valid` of the 16th byte. `frame_done` and `sync_error` follow the same rule relative to their triggering byte.
- `rx_valid` may be asserted on consecutive cycles, and every strobe is consumed. Bytes are never dropped or back-pressured.
- `reset_n` low mid-word discards the partial word immediately. The first byte after release is processed in HUNT.
- `word_valid` and `sync_error` are never asserted together. A timeout and a byte arriving in the same cycle: the byte wins and the timer restarts.

## Configuration
- `DEFRAMER_TIMEOUT_EN` defined: a 16-bit idle counter runs in DATA and RESYNC.
  - It clears on each `rx_valid`.
  - Reaching `TIMEOUT` → `sync_error`, HUNT, partial word discarded, `locked` cleared.
- `DEFRAMER_TIMEOUT_EN` undefined: no counter exists. The block waits indefinitely in DATA/RESYNC, and `TIMEOUT` is ignored.

## Test plan
- Full frame: 32 × (sync + 256 bytes), where word n has every byte = n[7:0]. Required: 512 `word_valid` strobes with addresses 0..511 in order, `word_data` = {16{n[7:0]}}, one `frame_done` with address 511, zero `sync_error`.
- HUNT threshold at `SYNC_MIN`=15: 14×0x55 + 0xAA → stays unlocked. Then 15×0x55 + 0xAA → `locked`=1, and the next 16 bytes 0x00..0x0F give `word_data`=0x000102…0F at address 0.
- Bad RESYNC: after 16 words, send 7×0x55 then 0x12. Required: `sync_error` one cycle later, `locked`=0. A subsequent sync plus 16 bytes yields address 0.
- Back-to-back `rx_valid` on every cycle for a full block. Required: 16 words, each `word_valid` exactly 1 cycle after the 16th byte.
- With `DEFRAMER_TIMEOUT_EN` and `TIMEOUT`=100: lock, send 5 bytes, then idle. Required: `sync_error` at idle cycle 100, HUNT. Without the macro: no error after 10000 idle cycles.
- Assert `reset_n` low after byte 9 of word 3 for 1 cycle. Required: all outputs 0 and `locked`=0. The following sync + word yields address 0.
